// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around one shared
// one-bit full-adder cell (src2). The operands are latched on a start
// handshake. They are added LSB first, one bit per clock, with a
// registered carry. The result is published with a one-cycle done pulse.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - add request, accepted only while ready=1
//   a_in  - operand A, sampled on the accept edge
//   b_in  - operand B, sampled on the accept edge
//   cin   - carry-in, sampled on the accept edge
//   ready - high only in IDLE
//   busy  - high only in RUN
//   done  - one-cycle pulse, high only in DONE
//   sum   - last completed result, held between operations
//   cout  - carry-out of the last completed result, held

// src2: one-bit full adder (x = sum, y = carry).
//   a, b, c - addend bits and carry-in
//   x       - sum bit
//   y       - carry-out bit
module src2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x,
    output logic y
);
    assign x = a ^ b ^ c;
    assign y = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The counter must hold WIDTH-1 without wrapping.
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               x_c;
    logic               y_c;
    logic               last_bit_c;
    logic [WIDTH-1:0]   acc_next_c;

    // The shared full-adder cell works on the current LSBs and the carry.
    src2 u_fa (
        .a (opa_q[0]),
        .b (opb_q[0]),
        .c (carry_q),
        .x (x_c),
        .y (y_c)
    );

    // Sum bits enter at the MSB, so after WIDTH shifts the LSB sits at bit 0.
    if (WIDTH == 1) begin : g_acc_w1
        assign acc_next_c = x_c;
    end else begin : g_acc_wn
        assign acc_next_c = {x_c, acc_q[WIDTH-1:1]};
    end

    assign last_bit_c = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)      state_d = S_RUN;
            S_RUN:   if (last_bit_c) state_d = S_DONE;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            S_IDLE:  ready = 1'b1;
            S_RUN:   busy  = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath: latch on accept, shift one bit per RUN cycle, publish on the last bit.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a_in;
                    opb_d   = b_in;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                acc_d   = acc_next_c;
                carry_d = y_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit_c) begin
                    sum_d  = acc_next_c;
                    cout_d = y_c;
                end
            end
            default: begin
                opa_d = opa_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8, WIDTH=1 and WIDTH=4.
module tb_serial_add_ctrl;

    logic clk;
    logic rst;

    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, ready1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    logic       start4, cin4, ready4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks;
    int failures;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );
    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 operation with timing checks around done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input string tag);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        step();                               // edge E
        start8 = 1'b0;
        chk({tag, "_busy_e1"}, 32'(busy8), 32'd1);
        chk({tag, "_ready_e1"}, 32'(ready8), 32'd0);
        repeat (7) step();                    // after E+7
        chk({tag, "_nodone_e7"}, 32'(done8), 32'd0);
        step();                               // after E+8
        chk({tag, "_done"}, 32'(done8), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy8), 32'd0);
        chk({tag, "_sum"}, 32'(sum8), 32'(es));
        chk({tag, "_cout"}, 32'(cout8), 32'(ec));
        step();                               // after E+9
        chk({tag, "_ready_back"}, 32'(ready8), 32'd1);
        chk({tag, "_done_off"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int rises;
        int r_at [3];
        int cyc;
        int n_done;
        logic prev_busy;
        logic [4:0] ref4;
        bit got;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_ready", 32'(ready8), 32'd1);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        rst = 1'b0;
        step();

        // Basic add and carry ripple / overflow
        run8(8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0, "basic");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf1");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ovf2");

        // Start re-pulsed during RUN and during DONE is ignored
        a8 = 8'h5A; b8 = 8'h25; cin8 = 1'b0; start8 = 1'b1;
        step();                               // E
        start8 = 1'b0;
        repeat (2) step();                    // after E+2
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        step();                               // E+3, in RUN
        start8 = 1'b0;
        chk("ign_run_busy", 32'(busy8), 32'd1);
        repeat (4) step();                    // after E+7
        chk("ign_nodone_e7", 32'(done8), 32'd0);
        step();                               // after E+8
        chk("ign_done", 32'(done8), 32'd1);
        chk("ign_sum", 32'(sum8), 32'h7F);
        chk("ign_cout", 32'(cout8), 32'd0);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        step();                               // E+9, sampled in DONE
        start8 = 1'b0;
        chk("ign_done_ready", 32'(ready8), 32'd1);
        chk("ign_done_busy", 32'(busy8), 32'd0);
        step();
        chk("ign_still_idle", 32'(ready8), 32'd1);

        // sum holds the old result through the next RUN
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (4) step();
        chk("hold_run_sum", 32'(sum8), 32'h7F);
        chk("hold_run_busy", 32'(busy8), 32'd1);
        repeat (4) step();                    // after E+8
        chk("hold_new_done", 32'(done8), 32'd1);
        chk("hold_new_sum", 32'(sum8), 32'h03);
        step();

        // Reset mid-run discards the operation
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        step();                               // E
        start8 = 1'b0;
        repeat (3) step();                    // after E+3
        rst = 1'b1;
        step();                               // E+4
        rst = 1'b0;
        chk("mrst_ready", 32'(ready8), 32'd1);
        chk("mrst_busy", 32'(busy8), 32'd0);
        chk("mrst_done", 32'(done8), 32'd0);
        chk("mrst_sum", 32'(sum8), 32'd0);
        chk("mrst_cout", 32'(cout8), 32'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) n_done++;
        end
        chk("mrst_no_done", 32'(n_done), 32'd0);
        run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "fresh");

        // Back-to-back with start held: accepts spaced WIDTH+2 apart
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        rises = 0; prev_busy = busy8;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (!prev_busy && busy8 && rises < 3) begin
                r_at[rises] = i;
                rises++;
            end
            prev_busy = busy8;
        end
        start8 = 1'b0;
        chk("b2b8_count", 32'(rises), 32'd3);
        if (rises == 3) begin
            chk("b2b8_gap1", 32'(r_at[1] - r_at[0]), 32'd10);
            chk("b2b8_gap2", 32'(r_at[2] - r_at[1]), 32'd10);
        end
        repeat (12) step();
        chk("b2b8_sum", 32'(sum8), 32'h30);
        chk("b2b8_idle", 32'(ready8), 32'd1);

        // WIDTH=1: 1+1+1
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        step();                               // E
        start1 = 1'b0;
        chk("w1_busy", 32'(busy1), 32'd1);
        chk("w1_nodone", 32'(done1), 32'd0);
        step();                               // after E+1
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_sum", 32'(sum1), 32'd1);
        chk("w1_cout", 32'(cout1), 32'd1);
        step();
        chk("w1_ready", 32'(ready1), 32'd1);

        // WIDTH=1 back-to-back spacing is 3
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
        rises = 0; prev_busy = busy1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (!prev_busy && busy1 && rises < 3) begin
                r_at[rises] = i;
                rises++;
            end
            prev_busy = busy1;
        end
        start1 = 1'b0;
        chk("b2b1_count", 32'(rises), 32'd3);
        if (rises == 3) begin
            chk("b2b1_gap1", 32'(r_at[1] - r_at[0]), 32'd3);
            chk("b2b1_gap2", 32'(r_at[2] - r_at[1]), 32'd3);
        end
        repeat (4) step();
        chk("b2b1_sum", 32'({cout1, sum1}), 32'd1);

        // WIDTH=4 exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    got = 1'b0;
                    cyc = 0;
                    while (!got && cyc < 10) begin
                        step();
                        cyc++;
                        if (done4) got = 1'b1;
                    end
                    ref4 = 5'(a + b + c);
                    if (!got) chk("sweep_timeout", 32'd0, 32'd1);
                    else chk($sformatf("sweep_%0h_%0h_%0d", a, b, c),
                             32'({cout4, sum4}), 32'(ref4));
                    step();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
